instr_fetch: RTL and testbench

Upstream instruction-fetch stage for simple_cpu. It holds a small writable instruction store and a program counter. It presents one 20-bit instruction at a time on the CPU's instruction input, holding each word for exactly as many cycles as the control unit needs to step through that instruction class. The program is loaded through a write port while the fetcher is idle. A start pulse runs the program until a HALT word is fetched.

---
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetcher for simple_cpu: writable store plus PC, holds each word for its CU step count.
// Latency: word registered on issue edge; backpressure: none, loads/start only honoured outside RUN.
module instr_fetch #(
   parameter int INSTR_WIDTH = 20,
   parameter int PC_BITS     = 5,
   parameter int STD_CYCLES  = 3,
   parameter int MEM_CYCLES  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_en,
   input  logic [PC_BITS-1:0]     load_addr,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   start,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [PC_BITS-1:0]     pc,
   output logic                   issue,
   output logic                   busy,
   output logic                   halted
);
   localparam int HW = $clog2(MEM_CYCLES + 2);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [PC_BITS-1:0]     pc_q, pc_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic                   issue_q, issue_d;

   logic [INSTR_WIDTH-1:0] mem_q [0:2**PC_BITS-1];
   logic [PC_BITS-1:0]     fetch_addr;
   logic [INSTR_WIDTH-1:0] rd_word;
   logic                   rd_halt;
   logic [HW-1:0]          rd_hold;
   logic                   fetch;
   logic                   first;

   // Store is not reset; writes are locked out in RUN so fetches never race a write.
   always_ff @(posedge clk) begin
      if (load_en && state_q != RUN) begin
         mem_q[load_addr] <= load_data;
      end
   end

   assign fetch_addr = (state_q == RUN) ? pc_q + PC_BITS'(1) : '0;
   assign rd_word    = mem_q[fetch_addr];
   assign rd_halt    = (rd_word[INSTR_WIDTH-1:INSTR_WIDTH-2] == 2'b00);
   assign rd_hold    = (rd_word[INSTR_WIDTH-1:INSTR_WIDTH-2] == 2'b01) ? HW'(STD_CYCLES - 1)
                                                                       : HW'(MEM_CYCLES - 1);

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      issue_d = 1'b0;
      fetch   = 1'b0;
      first   = 1'b0;
      case (state_q)
         IDLE, HALT: begin
            if (start && !load_en) begin
               fetch = 1'b1;
               first = 1'b1;
            end
         end
         RUN: begin
            if (hold_q == '0) begin
               fetch = 1'b1;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // First word gets one extra cycle for the CU's RESET->DECODE step.
      if (fetch) begin
         issue_d = 1'b1;
         pc_d    = fetch_addr;
         if (rd_halt) begin
            instr_d = '0;
            hold_d  = '0;
            state_d = HALT;
         end else begin
            instr_d = rd_word;
            hold_d  = rd_hold + HW'(first);
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= '0;
         pc_q    <= '0;
         hold_q  <= '0;
         issue_q <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         issue_q <= issue_d;
      end
   end

   assign instruction = instr_q;
   assign pc          = pc_q;
   assign issue       = issue_q;
   assign busy        = (state_q == RUN);
   assign halted      = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected per-cycle outputs queued at stimulus time, popped each cycle.
module tb_instr_fetch;
   logic        clk;
   logic        rst;
   logic        load_en;
   logic [4:0]  load_addr;
   logic [19:0] load_data;
   logic        start;
   logic [19:0] instruction;
   logic [4:0]  pc;
   logic        issue;
   logic        busy;
   logic        halted;

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .start       (start),
      .instruction (instruction),
      .pc          (pc),
      .issue       (issue),
      .busy        (busy),
      .halted      (halted)
   );

   typedef struct packed {
      logic [19:0] instr;
      logic [4:0]  pc;
      logic        issue;
      logic        busy;
      logic        halted;
   } obs_t;

   obs_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [19:0] w, input logic [4:0] p,
                               input logic is, input logic b, input logic h);
      obs_t o;
      o.instr = w; o.pc = p; o.issue = is; o.busy = b; o.halted = h;
      return o;
   endfunction

   function automatic obs_t cur();
      return mk(instruction, pc, issue, busy, halted);
   endfunction

   task automatic check(input string tag, input obs_t got, input obs_t exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got instr=%h pc=%0d issue=%b busy=%b halted=%b, expected instr=%h pc=%0d issue=%b busy=%b halted=%b",
                tag, got.instr, got.pc, got.issue, got.busy, got.halted,
                exp.instr, exp.pc, exp.issue, exp.busy, exp.halted);
      end
   endtask

   task automatic push_word(input logic [19:0] w, input logic [4:0] p, input int n);
      for (int i = 0; i < n; i++) sb.push_back(mk(w, p, (i == 0), 1'b1, 1'b0));
   endtask

   task automatic push_halt(input logic [4:0] p);
      sb.push_back(mk(20'h0, p, 1'b1, 1'b0, 1'b1));
      sb.push_back(mk(20'h0, p, 1'b0, 1'b0, 1'b1));
   endtask

   // One clock: controls set before the call are seen by exactly one edge.
   task automatic step(input string tag);
      obs_t e;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      load_en = 1'b0;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s: scoreboard empty, observed pc=%0d", tag, pc);
      end else begin
         e = sb.pop_front();
         check(tag, cur(), e);
      end
   endtask

   task automatic steps(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic drain(input string tag);
      while (sb.size() > 0) step(tag);
   endtask

   task automatic load(input logic [4:0] a, input logic [19:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
      #1;
      check("reset_initial", cur(), mk(20'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Mixed std/loadR program ending in HALT
      load(5'd0, 20'h51230);
      load(5'd1, 20'h90034);
      load(5'd2, 20'h00000);
      push_word(20'h51230, 5'd0, 4);
      push_word(20'h90034, 5'd1, 4);
      push_halt(5'd2);
      start = 1'b1;
      drain("mixed");

      // Back-to-back std words, started from HALT
      load(5'd0, 20'h41200);
      load(5'd1, 20'h50100);
      load(5'd2, 20'h62300);
      load(5'd3, 20'h00000);
      push_word(20'h41200, 5'd0, 4);
      push_word(20'h50100, 5'd1, 3);
      push_word(20'h62300, 5'd2, 3);
      push_halt(5'd3);
      start = 1'b1;
      drain("std_b2b");

      // storeR first word, restart from HALT
      load(5'd0, 20'hC0010);
      load(5'd1, 20'h00000);
      push_word(20'hC0010, 5'd0, 5);
      push_halt(5'd1);
      start = 1'b1;
      drain("restart");

      // Wrap through all 32 words, with ignored load/start during RUN
      for (int a = 0; a < 32; a++) load(a[4:0], 20'h40000);
      push_word(20'h40000, 5'd0, 4);
      for (int p = 1; p < 32; p++) push_word(20'h40000, p[4:0], 3);
      push_word(20'h40000, 5'd0, 3);
      push_word(20'h40000, 5'd1, 3);
      start = 1'b1;
      steps("wrap", 5);
      load_en = 1'b1; load_addr = 5'd5; load_data = 20'h00000; start = 1'b1;
      drain("wrap_ignored");

      // Reset mid-RUN: outputs clear without an edge, store survives
      push_word(20'h40000, 5'd2, 3);
      steps("run_more", 1);
      #2 rst = 1'b1;
      #1;
      check("reset_midrun", cur(), mk(20'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(mk(20'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      step("idle_after_reset");
      push_word(20'h40000, 5'd0, 4);
      push_word(20'h40000, 5'd1, 3);
      start = 1'b1;
      steps("store_kept", 7);
      sb.delete();

      // Mid-RUN reset again, then HALT word at address 0 halts immediately
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      load(5'd0, 20'h00000);
      push_halt(5'd0);
      start = 1'b1;
      drain("halt_at_0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
